// File: rtl/debug_pkg.sv
// Shared types and constants for the UART debug loader: FSM states,
// command bytes and snapshot geometry.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_WAIT_MODE,
    ST_RUN,
    ST_STEP_IDLE,
    ST_STEP_EXEC,
    ST_SEND,
    ST_HALTED
  } state_t;

  localparam logic [7:0] CMD_STEP_MODE  = 8'hFF;
  localparam logic [7:0] CMD_RUN        = 8'h55;
  localparam logic [7:0] CMD_STEP       = 8'hAA;
  localparam logic [5:0] HALT_OPCODE    = 6'b111111;
  localparam int         SNAPSHOT_BYTES = 8;

endpackage

// File: rtl/debug_tx_serializer.sv
// Streams a snapshot out LSB-first, one byte per transmit request, waiting
// for the UART to report completion before issuing the next request.
module debug_tx_serializer #(
  parameter int BYTE_W = 8,
  parameter int NBYTES = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NBYTES*BYTE_W-1:0] i_snapshot,
  input  logic                     i_start,
  input  logic                     i_tx_done,
  output logic [BYTE_W-1:0]        o_tx_byte,
  output logic                     o_tx_signal,
  output logic                     o_done
);

  localparam int IDX_W = $clog2(NBYTES);

  logic [NBYTES*BYTE_W-1:0] shift_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic                     busy_reg;
  logic                     tx_signal_reg;
  logic                     done_reg;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_reg     <= '0;
      idx_reg       <= '0;
      busy_reg      <= 1'b0;
      tx_signal_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      tx_signal_reg <= 1'b0;
      done_reg      <= 1'b0;
      if (!busy_reg && i_start) begin
        shift_reg     <= i_snapshot;
        idx_reg       <= '0;
        busy_reg      <= 1'b1;
        tx_signal_reg <= 1'b1;
      // A completion coinciding with our own request cannot belong to it.
      end else if (busy_reg && i_tx_done && !tx_signal_reg) begin
        if (idx_reg == IDX_W'(NBYTES - 1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          shift_reg     <= shift_reg >> BYTE_W;
          idx_reg       <= idx_reg + 1'b1;
          tx_signal_reg <= 1'b1;
        end
      end
    end
  end

  assign o_tx_byte   = shift_reg[BYTE_W-1:0];
  assign o_tx_signal = tx_signal_reg;
  assign o_done      = done_reg;

endmodule

// File: rtl/debug_loader.sv
// UART debug controller: loads instruction words into imem, then gates the
// pipeline for run/step and streams PC / write-back snapshots back out.
module debug_loader
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int ADDR_WIDTH      = 5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [DATA_WIDTH_UART-1:0] i_rx_byte,
  input  logic                       i_rx_done,
  input  logic                       i_tx_done,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  input  logic [DATA_WIDTH-1:0]      i_result_wb,
  input  logic                       i_halt,
  output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
  output logic                       o_tx_signal,
  output logic                       o_imem_we,
  output logic [ADDR_WIDTH-1:0]      o_imem_addr,
  output logic [DATA_WIDTH-1:0]      o_imem_data,
  output logic                       o_cpu_enable,
  output logic                       o_halted
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        byte_cnt_reg;
  logic [DATA_WIDTH-1:0]   word_assembled;
  logic                    imem_we_reg;
  logic [ADDR_WIDTH-1:0]   imem_addr_reg;
  logic [DATA_WIDTH-1:0]   imem_data_reg;
  logic                    exec_phase_reg;
  logic                    halt_seen_reg;
  logic                    send_started_reg;
  logic [2*DATA_WIDTH-1:0] snapshot_reg;
  logic                    load_strobe, word_done, capture, cpu_enable;
  logic                    ser_start, ser_done;

  assign load_strobe = (state_reg == ST_LOAD) && i_rx_done;
  assign word_done   = load_strobe && (byte_cnt_reg == CNT_W'(BYTES_PER_WORD - 1));

  // The lane receiving the current byte bypasses its register so the full
  // word is available in the same cycle as the final byte.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    logic [DATA_WIDTH_UART-1:0] lane_reg;
    always_ff @(posedge i_clock) begin
      if (i_reset) lane_reg <= '0;
      else if (load_strobe && byte_cnt_reg == CNT_W'(gi)) lane_reg <= i_rx_byte;
    end
    assign word_assembled[gi*DATA_WIDTH_UART +: DATA_WIDTH_UART] =
      (byte_cnt_reg == CNT_W'(gi)) ? i_rx_byte : lane_reg;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg        <= ST_LOAD;
      byte_cnt_reg     <= '0;
      imem_we_reg      <= 1'b0;
      imem_addr_reg    <= '0;
      imem_data_reg    <= '0;
      exec_phase_reg   <= 1'b0;
      halt_seen_reg    <= 1'b0;
      send_started_reg <= 1'b0;
      snapshot_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      imem_we_reg <= word_done;
      if (load_strobe) byte_cnt_reg <= byte_cnt_reg + 1'b1;
      if (word_done) imem_data_reg <= word_assembled;
      if (imem_we_reg && imem_addr_reg != ADDR_LAST) imem_addr_reg <= imem_addr_reg + 1'b1;
      exec_phase_reg <= (state_reg == ST_STEP_EXEC) && !exec_phase_reg;
      if (capture) snapshot_reg <= {i_result_wb, i_pc};
      if ((state_reg == ST_RUN || state_reg == ST_STEP_EXEC) && i_halt) halt_seen_reg <= 1'b1;
      else if (ser_done) halt_seen_reg <= 1'b0;
      send_started_reg <= (state_reg == ST_SEND) && (send_started_reg || ser_start);
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    cpu_enable = 1'b0;
    ser_start  = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        if (word_done && (word_assembled[DATA_WIDTH-1 -: 6] == HALT_OPCODE ||
                          imem_addr_reg == ADDR_LAST))
          state_next = ST_WAIT_MODE;
      end
      ST_WAIT_MODE: begin
        if (i_rx_done && i_rx_byte == CMD_STEP_MODE) state_next = ST_STEP_IDLE;
        else if (i_rx_done && i_rx_byte == CMD_RUN) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_halt) begin
          capture    = 1'b1;
          state_next = ST_SEND;
        end else begin
          cpu_enable = 1'b1;
        end
      end
      ST_STEP_IDLE: begin
        if (i_rx_done && i_rx_byte == CMD_STEP) state_next = ST_STEP_EXEC;
      end
      // First cycle advances the pipeline; second samples its new state.
      ST_STEP_EXEC: begin
        if (!exec_phase_reg) begin
          cpu_enable = 1'b1;
        end else begin
          capture    = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        ser_start = !send_started_reg;
        if (ser_done) state_next = halt_seen_reg ? ST_HALTED : ST_STEP_IDLE;
      end
      ST_HALTED: ;
      default: state_next = ST_LOAD;
    endcase
  end

  debug_tx_serializer #(
    .BYTE_W(DATA_WIDTH_UART),
    .NBYTES(SNAPSHOT_BYTES)
  ) u_tx_serializer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_snapshot (snapshot_reg),
    .i_start    (ser_start),
    .i_tx_done  (i_tx_done),
    .o_tx_byte  (o_tx_byte),
    .o_tx_signal(o_tx_signal),
    .o_done     (ser_done)
  );

  assign o_imem_we    = imem_we_reg;
  assign o_imem_addr  = imem_addr_reg;
  assign o_imem_data  = imem_data_reg;
  assign o_cpu_enable = cpu_enable;
  assign o_halted     = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_debug_loader.sv
// Directed/randomized bench for debug_loader: a behavioural load model,
// a UART transmitter responder and snapshot byte expectations.
module tb_debug_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_rx_byte;
  logic        i_rx_done;
  logic        i_tx_done;
  logic [31:0] i_pc;
  logic [31:0] i_result_wb;
  logic        i_halt;
  logic [7:0]  o_tx_byte;
  logic        o_tx_signal;
  logic        o_imem_we;
  logic [4:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic        o_cpu_enable;
  logic        o_halted;

  always #5 clk = ~clk;

  debug_loader dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_rx_byte   (i_rx_byte),
    .i_rx_done   (i_rx_done),
    .i_tx_done   (i_tx_done),
    .i_pc        (i_pc),
    .i_result_wb (i_result_wb),
    .i_halt      (i_halt),
    .o_tx_byte   (o_tx_byte),
    .o_tx_signal (o_tx_signal),
    .o_imem_we   (o_imem_we),
    .o_imem_addr (o_imem_addr),
    .o_imem_data (o_imem_data),
    .o_cpu_enable(o_cpu_enable),
    .o_halted    (o_halted)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int en_last_cyc = 0;
  int tx_viol = 0;
  int strobe_cyc = 0;
  logic [4:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_imem_we) begin
      wr_addr_q.push_back(o_imem_addr);
      wr_data_q.push_back(o_imem_data);
    end
    if (o_cpu_enable) begin
      en_cnt      <= en_cnt + 1;
      en_last_cyc <= cyc;
    end
  end

  // UART transmitter: accept a byte, hold it busy for a random time, then
  // pulse i_tx_done. No new request and no byte change allowed while busy.
  always begin : uart_model
    logic [7:0] cur;
    int d;
    @(negedge clk);
    if (o_tx_signal) begin
      cur = o_tx_byte;
      tx_q.push_back(cur);
      tx_cyc_q.push_back(cyc);
      d = $urandom_range(1, 4);
      repeat (d) begin
        @(negedge clk);
        if (o_tx_signal || o_tx_byte !== cur) tx_viol <= tx_viol + 1;
      end
      @(posedge clk); #1 i_tx_done = 1'b1;
      @(posedge clk); #1 i_tx_done = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_byte  = b;
    i_rx_done  = 1'b1;
    strobe_cyc = cyc;
    tick(1);
    i_rx_done = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, 2));
  endtask

  task automatic clear_queues();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
    tx_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_queues();
  endtask

  // Loader model: words go to consecutive addresses from 0; loading stops
  // after a halt word or after the last address is written.
  task automatic expect_writes(input string tag, input logic [31:0] words[$]);
    int n = 0;
    for (int i = 0; i < words.size(); i++) begin
      logic [31:0] obs_d;
      logic [4:0]  obs_a;
      obs_a = (n < wr_addr_q.size()) ? wr_addr_q[n] : 5'bx;
      obs_d = (n < wr_data_q.size()) ? wr_data_q[n] : 32'bx;
      check({tag, "_addr"}, 64'(obs_a), 64'(i));
      check({tag, "_data"}, 64'(obs_d), 64'(words[i]));
      n++;
      if (words[i][31:26] == 6'h3F || i == 31) break;
    end
    check({tag, "_count"}, 64'(wr_addr_q.size()), 64'(n));
  endtask

  task automatic wait_tx(input string tag, input int n);
    int t = 0;
    while (tx_q.size() < n && t < 2000) begin
      tick(1);
      t++;
    end
    check({tag, "_tx_count"}, 64'(tx_q.size()), 64'(n));
  endtask

  task automatic expect_snapshot(input string tag, input logic [31:0] pc, input logic [31:0] wb);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_b;
      logic [7:0] obs_b;
      exp_b = (i < 4) ? pc[8*i +: 8] : wb[8*(i-4) +: 8];
      obs_b = (i < tx_q.size()) ? tx_q[i] : 8'bx;
      check($sformatf("%s_byte%0d", tag, i), 64'(obs_b), 64'(exp_b));
    end
  endtask

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] words[$];
    logic [31:0] w, pc, wb;
    logic [7:0]  b;
    int          en0, s;

    rst = 1'b1; i_rx_byte = '0; i_rx_done = 1'b0; i_tx_done = 1'b0;
    i_pc = '0; i_result_wb = '0; i_halt = 1'b0;
    tick(3);
    check("rst_tx_byte", 64'(o_tx_byte), 64'h0);
    check("rst_tx_signal", 64'(o_tx_signal), 64'h0);
    check("rst_imem_we", 64'(o_imem_we), 64'h0);
    check("rst_imem_addr", 64'(o_imem_addr), 64'h0);
    check("rst_imem_data", 64'(o_imem_data), 64'h0);
    check("rst_cpu_enable", 64'(o_cpu_enable), 64'h0);
    check("rst_halted", 64'(o_halted), 64'h0);
    rst = 1'b0;
    clear_queues();

    // Three words ending in a halt word; the trailing word must be ignored.
    words = '{32'h20430005, 32'h10220001, 32'hFC000000, 32'h11223344};
    foreach (words[i]) send_word(words[i]);
    tick(4);
    expect_writes("load3", words);
    check("load3_addr_after", 64'(o_imem_addr), 64'd3);

    // Step mode; a non-step byte in STEP_IDLE does nothing.
    send_byte(8'hFF, 2);
    en0 = en_cnt;
    send_byte(8'h12, 3);
    check("idle_ignore_en", 64'(en_cnt - en0), 64'd0);
    check("idle_ignore_tx", 64'(tx_q.size()), 64'd0);

    i_pc = 32'h00000004; i_result_wb = 32'h0000000D;
    send_byte(8'hAA, 0);
    s = strobe_cyc;
    tick(3);
    send_byte(8'hAA, 0);    // arrives during SEND: must be dropped
    wait_tx("step0", 8);
    tick(12);
    check("step0_en_pulses", 64'(en_cnt - en0), 64'd1);
    check("step0_en_cycle", 64'(en_last_cyc - s), 64'd1);
    check("step0_first_tx_cycle", 64'(tx_cyc_q[0] - s), 64'd4);
    check("step0_tx_total", 64'(tx_q.size()), 64'd8);
    expect_snapshot("step0", 32'h00000004, 32'h0000000D);

    for (int k = 0; k < 3; k++) begin
      tx_q.delete();
      tx_cyc_q.delete();
      pc = $urandom; wb = $urandom;
      i_pc = pc; i_result_wb = wb;
      b = 8'($urandom_range(0, 255));
      if (b == 8'hAA) b = 8'h00;
      en0 = en_cnt;
      send_byte(b, 2);
      send_byte(8'hAA, 0);
      wait_tx($sformatf("step%0d", k + 1), 8);
      tick(12);
      check($sformatf("step%0d_en_pulses", k + 1), 64'(en_cnt - en0), 64'd1);
      expect_snapshot($sformatf("step%0d", k + 1), pc, wb);
    end

    // Full 32-word load: no wrap, extra word ignored.
    do_reset();
    words.delete();
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      if (w[31:26] == 6'h3F) w[31] = 1'b0;
      words.push_back(w);
    end
    words.push_back(32'h01020304);
    foreach (words[i]) send_word(words[i]);
    tick(4);
    expect_writes("load32", words);
    check("load32_addr_nowrap", 64'(o_imem_addr), 64'd31);

    // Run until halt.
    en0 = en_cnt;
    send_byte(8'h55, 0);
    tick(10);
    pc = $urandom; wb = $urandom;
    i_pc = pc; i_result_wb = wb;
    i_halt = 1'b1;
    @(negedge clk);
    check("run_en_drop", 64'(o_cpu_enable), 64'd0);
    check("run_en_cycles", 64'(en_cnt - en0), 64'd10);
    wait_tx("run", 8);
    tick(12);
    expect_snapshot("run", pc, wb);
    check("run_halted", 64'(o_halted), 64'd1);
    en0 = en_cnt;
    send_byte(8'hFF, 1);
    send_byte(8'hAA, 1);
    send_byte(8'h55, 1);
    tick(6);
    check("halted_no_en", 64'(en_cnt - en0), 64'd0);
    check("halted_no_tx", 64'(tx_q.size()), 64'd8);
    check("halted_sticky", 64'(o_halted), 64'd1);
    i_halt = 1'b0;

    // Reset mid-word discards the partial word.
    do_reset();
    check("rst_clears_halted", 64'(o_halted), 64'd0);
    send_byte(8'h5A, 1);
    send_byte(8'hC3, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_queues();
    w = $urandom;
    send_word(w);
    tick(4);
    check("midrst_count", 64'(wr_addr_q.size()), 64'd1);
    check("midrst_addr", 64'((wr_addr_q.size() > 0) ? wr_addr_q[0] : 5'bx), 64'd0);
    check("midrst_data", 64'((wr_data_q.size() > 0) ? wr_data_q[0] : 32'bx), 64'(w));

    check("tx_handshake", 64'(tx_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_loader.md
# debug_loader

Byte-level debug controller sitting between the UART and the MIPS pipeline inside the top level, directly downstream of the UART receiver. It assembles received bytes into 32-bit instructions and writes them to instruction memory. It then accepts run and step commands that gate the pipeline enable. After each step, and when execution halts, it streams a PC / write-back snapshot back out through the UART transmitter.

## Interface
- DATA_WIDTH, 32, instruction/data word width
- DATA_WIDTH_UART, 8, UART byte width
- ADDR_WIDTH, 5, instruction memory word-address width (32 words)
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset; one clock
- i_rx_byte  in  8  byte from UART receiver
- i_rx_done  in  1  one-cycle strobe, i_rx_byte valid
- i_tx_done  in  1  one-cycle strobe, UART finished current byte
- i_pc  in  32  current pipeline PC
- i_result_wb  in  32  current write-back result
- i_halt  in  1  pipeline has retired the halt instruction (opcode 6'b111111)
- o_tx_byte  out  8  byte to UART transmitter
- o_tx_signal  out  1  one-cycle transmit request
- o_imem_we  out  1  instruction memory write enable
- o_imem_addr  out  ADDR_WIDTH  instruction memory word address
- o_imem_data  out  32  instruction word
- o_cpu_enable  out  1  pipeline clock enable
- o_halted  out  1  execution finished; sticky until reset

## Operation
- States: LOAD, WAIT_MODE, RUN, STEP_IDLE, STEP_EXEC, SEND, HALTED.
- LOAD: bytes arrive LSB first, four per word, byte counter 0..3.
  - On the 4th byte, pulse o_imem_we with the assembled word, then increment the address.
  - Go to WAIT_MODE when the written word has opcode 6'b111111 (halt; it is still written) or when address 2^ADDR_WIDTH-1 has been written. The address never wraps.
- WAIT_MODE commands:
  - 0xFF: go to STEP_IDLE.
  - 0x55: go to RUN, o_cpu_enable=1.
  - Any other byte: ignored.
- RUN: o_cpu_enable stays high. When i_halt=1, drop o_cpu_enable the same cycle, capture the snapshot, then SEND, then HALTED. Rx bytes are ignored.
- STEP_IDLE: 0xAA goes to STEP_EXEC. Other bytes are ignored.
- STEP_EXEC: o_cpu_enable=1 for exactly one cycle. Capture {i_result_wb, i_pc} on the following cycle, then go to SEND.
- SEND: transmit 8 bytes: PC[7:0]..PC[31:24], then WB[7:0]..WB[31:24].
  - Each byte gets one o_tx_signal pulse. The next pulse waits for i_tx_done.
  - After the 8th i_tx_done: go to HALTED if i_halt was seen (latched), else STEP_IDLE.
  - Rx bytes are dropped during SEND.
- HALTED: o_halted=1, o_cpu_enable=0, all rx ignored until reset.

## Timing
- Reset values: state LOAD; o_tx_byte, o_tx_signal, o_imem_we, o_imem_addr, o_imem_data, o_cpu_enable, o_halted all 0; byte counter 0.
- Load latency: o_imem_we asserts the cycle after the 4th i_rx_done, for one cycle, with address and data stable. o_imem_addr increments the cycle after.
- Step: o_cpu_enable asserts the cycle after the i_rx_done carrying 0xAA. Snapshot is registered 2 cycles after that strobe. First o_tx_signal pulse occurs 1 cycle after the snapshot.
- o_tx_byte is valid from the o_tx_signal cycle until the matching i_tx_done.
- i_rx_done and i_tx_done arriving in the same cycle: each is handled independently; the rx byte is dropped if the state ignores rx.
- i_halt is sampled every cycle in RUN and STEP_EXEC and latched until SEND completes.
- Reset mid-load or mid-send aborts immediately: partial word discarded, no further o_tx_signal.

## Structure
- Package debug_pkg holds:
  - state enum
  - command constants CMD_STEP_MODE=8'hFF, CMD_RUN=8'h55, CMD_STEP=8'hAA
  - HALT_OPCODE=6'b111111
  - SNAPSHOT_BYTES=8
- Sub-module debug_tx_serializer takes a 64-bit snapshot, start and i_tx_done, and produces o_tx_byte, o_tx_signal and done. It owns the byte index and the wait-for-done handshake.

## Test plan
- Load 3 words 0x20430005, 0x10220001, 0xFC000000 LSB-first -> three o_imem_we pulses at addr 0,1,2 with exact data; state WAIT_MODE; the 4th word sent is not written.
- Load 32 non-halt words -> 32 writes at addr 0..31, no wrap, then WAIT_MODE.
- 0xFF then 0xAA with i_pc=0x00000004, i_result_wb=0x0000000D -> exactly one o_cpu_enable cycle; tx bytes 04,00,00,00,0D,00,00,00, each only after i_tx_done.
- 0xAA received during SEND, and 0x12 received in STEP_IDLE -> both ignored, no extra enable pulse.
- 0x55 run, raise i_halt after 10 cycles -> o_cpu_enable low the same cycle, 8-byte snapshot sent, o_halted=1; later bytes ignored.
- Reset asserted after 2 bytes of a word -> no write; the next 4 bytes are written at addr 0.
